// File: rtl/lcd_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : lcd_rd_sched
// Description : LCD frame read scheduler. On every frame_start it flushes the
//               pixel FIFO, then walks the frame buffer from BASE_ADDR in
//               bursts of up to BURST_LEN words. A burst is issued only when
//               the FIFO has room for all of it, and only one read is ever
//               outstanding. Also counts LCD underrun cycles.
// Ports       : lcd_pclk, rst_n          - pixel clock, async active-low reset
//               frame_start              - vsync pulse, (re)starts a frame
//               fifo_wr_cnt, fifo_empty  - pixel FIFO status
//               data_req                 - LCD pops one pixel per high cycle
//               rd_req/rd_addr/rd_len    - read request (held until rd_ack)
//               rd_ack, rd_done          - request accepted / data landed
//               fifo_flush               - FIFO clear, FLUSH_CYC cycles long
//               frame_done               - one-cycle pulse, frame fetched
//               late_frame               - sticky, vsync beat the fetch
//               underrun_cnt             - saturating underrun cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_rd_sched #(
    parameter int          H_DISP     = 800,
    parameter int          V_DISP     = 480,
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_DEPTH = 512,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          FLUSH_CYC  = 4
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [9:0]  fifo_wr_cnt,
    input  logic        fifo_empty,
    input  logic        data_req,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    output logic [7:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        fifo_flush,
    output logic        frame_done,
    output logic        late_frame,
    output logic [15:0] underrun_cnt
);

    localparam logic [18:0] c_TOTAL_PIX  = 19'(H_DISP * V_DISP);
    localparam logic [18:0] c_BURST_PIX  = 19'(BURST_LEN);
    localparam logic [7:0]  c_BURST_LEN  = 8'(BURST_LEN);
    localparam logic [7:0]  c_FLUSH_LAST = 8'(FLUSH_CYC - 1);
    localparam logic [31:0] c_FIFO_DEPTH = 32'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_CHECK = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [23:0] r_addr;
    logic [18:0] r_pix_left;
    logic [7:0]  r_flush_cnt;
    logic        r_pending;

    logic [7:0]  w_burst_len;
    logic [31:0] w_fill_after;
    logic        w_fits;
    logic        w_restart;
    logic        w_late;

    // Last burst of a frame is whatever is left; it is never above BURST_LEN,
    // so the low byte of the counter holds it exactly.
    assign w_burst_len  = (r_pix_left > c_BURST_PIX) ? c_BURST_LEN : r_pix_left[7:0];
    // Compare as "fill + len <= depth" so an over-reported fill level can
    // never wrap into a false "room available".
    assign w_fill_after = {22'd0, fifo_wr_cnt} + {24'd0, w_burst_len};
    assign w_fits       = (w_fill_after <= c_FIFO_DEPTH);

    // Restart points: a fresh vsync while not in a handshake, or the end of
    // an in-flight read once a vsync has been seen during it.
    always_comb begin
        w_restart = 1'b0;
        case (r_state)
            S_IDLE, S_FLUSH, S_CHECK, S_DONE: w_restart = frame_start;
            S_WAIT:  w_restart = rd_done && (r_pending || frame_start);
            default: w_restart = 1'b0;
        endcase
    end

    // Vsync in DONE is on time: the whole frame was already fetched.
    assign w_late = frame_start &&
                    ((r_state == S_FLUSH) || (r_state == S_CHECK) ||
                     (r_state == S_REQ)   || (r_state == S_WAIT));

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= 24'd0;
            r_pix_left  <= 19'd0;
            r_flush_cnt <= 8'd0;
            r_pending   <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= 24'd0;
            rd_len      <= 8'd0;
            fifo_flush  <= 1'b0;
            frame_done  <= 1'b0;
            late_frame  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_late) begin
                late_frame <= 1'b1;
            end

            if (w_restart) begin
                r_addr      <= BASE_ADDR;
                r_pix_left  <= c_TOTAL_PIX;
                r_flush_cnt <= 8'd0;
                r_pending   <= 1'b0;
                fifo_flush  <= 1'b1;
                r_state     <= S_FLUSH;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_FLUSH: begin
                        if (r_flush_cnt == c_FLUSH_LAST) begin
                            fifo_flush <= 1'b0;
                            r_state    <= S_CHECK;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + 8'd1;
                        end
                    end
                    S_CHECK: begin
                        if (r_pix_left == 19'd0) begin
                            frame_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (w_fits) begin
                            rd_req  <= 1'b1;
                            rd_addr <= r_addr;
                            rd_len  <= w_burst_len;
                            r_state <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        // The handshake always completes; a vsync here is
                        // only remembered and acted on after rd_done.
                        if (frame_start) begin
                            r_pending <= 1'b1;
                        end
                        if (rd_ack) begin
                            rd_req  <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (frame_start) begin
                            r_pending <= 1'b1;
                        end
                        if (rd_done) begin
                            r_addr     <= r_addr + {16'd0, rd_len};
                            r_pix_left <= r_pix_left - {11'd0, rd_len};
                            r_state    <= S_CHECK;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Underrun: the LCD wants a pixel and the FIFO has none. Cycles spent
    // flushing are expected to starve the LCD and are not counted.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= 16'd0;
        end else if (data_req && fifo_empty && (r_state != S_FLUSH) &&
                     (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_rd_sched
// Description : Directed self-checking bench for lcd_rd_sched. Uses a small
//               200-pixel frame (4 bursts: 64,64,64,8) with a base address
//               near the top of the 24-bit space so the address wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_rd_sched;

    localparam logic [23:0] c_BASE = 24'hFFFF80;

    logic        lcd_pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  fifo_wr_cnt = 10'd0;
    logic        fifo_empty = 1'b0;
    logic        data_req = 1'b0;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack = 1'b0;
    logic        rd_done = 1'b0;
    logic        fifo_flush;
    logic        frame_done;
    logic        late_frame;
    logic [15:0] underrun_cnt;

    int checks = 0;
    int errors = 0;

    lcd_rd_sched #(
        .H_DISP     (20),
        .V_DISP     (10),
        .BURST_LEN  (64),
        .FIFO_DEPTH (512),
        .BASE_ADDR  (c_BASE),
        .FLUSH_CYC  (4)
    ) dut (
        .lcd_pclk     (lcd_pclk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .fifo_wr_cnt  (fifo_wr_cnt),
        .fifo_empty   (fifo_empty),
        .data_req     (data_req),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_ack       (rd_ack),
        .rd_done      (rd_done),
        .fifo_flush   (fifo_flush),
        .frame_done   (frame_done),
        .late_frame   (late_frame),
        .underrun_cnt (underrun_cnt)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge lcd_pclk);
        #1;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Counts consecutive fifo_flush cycles starting from the current sample.
    task automatic test_flush_len(input string name);
        int n;
        n = 0;
        while (fifo_flush && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL %s: fifo_flush high for %0d cycles, expected 4", name, n);
        end
    endtask

    // One read transaction: wait for the request, check it, optionally hold
    // rd_ack off (with a stray rd_done thrown in), ack, then rd_done 8 later.
    // With late set, frame_start is pulsed during WAIT.
    task automatic do_burst(input logic [23:0] exp_addr, input logic [7:0] exp_len,
                            input int hold, input bit late, input string name);
        int n;
        n = 0;
        while (!rd_req && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (rd_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req: rd_req=%b after %0d cycles, expected 1", name, rd_req, n);
        end
        checks++;
        if (rd_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_addr: rd_addr=%h expected %h", name, rd_addr, exp_addr);
        end
        checks++;
        if (rd_len !== exp_len) begin
            errors++;
            $display("FAIL %s_len: rd_len=%0d expected %0d", name, rd_len, exp_len);
        end
        for (int i = 0; i < hold; i++) begin
            rd_done = (i == 5);
            tick();
            checks++;
            if (rd_req !== 1'b1 || rd_addr !== exp_addr || rd_len !== exp_len) begin
                errors++;
                $display("FAIL %s_hold: cycle %0d req=%b addr=%h len=%0d expected 1 %h %0d",
                         name, i, rd_req, rd_addr, rd_len, exp_addr, exp_len);
            end
        end
        rd_done = 1'b0;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        checks++;
        if (rd_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_drop: rd_req=%b after ack, expected 0", name, rd_req);
        end
        if (late) begin
            pulse_frame_start();
            checks++;
            if (late_frame !== 1'b1) begin
                errors++;
                $display("FAIL %s_late: late_frame=%b expected 1", name, late_frame);
            end
            repeat (6) tick();
        end else begin
            repeat (7) tick();
        end
        checks++;
        if (fifo_flush !== 1'b0 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: flush=%b req=%b in WAIT, expected 0 0", name, fifo_flush, rd_req);
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        int n;
        n = 0;
        while (!frame_done && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: frame_done=%b expected 1", name, frame_done);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: frame_done=%b one cycle later, expected 0", name, frame_done);
        end
        n = 0;
        repeat (10) begin
            tick();
            if (rd_req) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL %s_extra_req: rd_req seen %0d cycles after frame, expected 0", name, n);
        end
    endtask

    task automatic test_reset();
        int n;
        tick();
        tick();
        checks++;
        if ({rd_req, rd_addr, rd_len, fifo_flush, frame_done, late_frame, underrun_cnt} !== 52'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h len=%0d flush=%b done=%b late=%b urun=%0d, expected all 0",
                     rd_req, rd_addr, rd_len, fifo_flush, frame_done, late_frame, underrun_cnt);
        end
        rst_n = 1'b1;
        tick();
        // A stray rd_done in IDLE must not move the address.
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        n = 0;
        repeat (10) begin
            tick();
            if (rd_req || fifo_flush) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_idle: req/flush active %0d cycles before frame_start, expected 0", n);
        end
    endtask

    task automatic test_full_frame();
        pulse_frame_start();
        test_flush_len("full_flush");
        do_burst(24'hFFFF80, 8'd64, 0, 1'b0, "full_b0");
        do_burst(24'hFFFFC0, 8'd64, 0, 1'b0, "full_b1");
        do_burst(24'h000000, 8'd64, 0, 1'b0, "full_b2");
        do_burst(24'h000040, 8'd8,  0, 1'b0, "full_b3");
        finish_frame("full");
        checks++;
        if (late_frame !== 1'b0) begin
            errors++;
            $display("FAIL full_late: late_frame=%b expected 0", late_frame);
        end
    endtask

    task automatic test_backpressure();
        int n;
        fifo_wr_cnt = 10'd460;
        pulse_frame_start();
        n = 0;
        repeat (24) begin
            tick();
            if (rd_req) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL bp_block: rd_req high %0d cycles with fill 460, expected 0", n);
        end
        fifo_wr_cnt = 10'd448;
        tick();
        checks++;
        if (rd_req !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: rd_req=%b one cycle after fill 448, expected 1", rd_req);
        end
        fifo_wr_cnt = 10'd0;
        do_burst(24'hFFFF80, 8'd64, 0, 1'b0, "bp_b0");
    endtask

    task automatic test_hold();
        do_burst(24'hFFFFC0, 8'd64, 20, 1'b0, "hold_b1");
    endtask

    task automatic test_late_frame();
        do_burst(24'h000000, 8'd64, 0, 1'b1, "late_b2");
        checks++;
        if (fifo_flush !== 1'b1) begin
            errors++;
            $display("FAIL late_flush_start: fifo_flush=%b after rd_done, expected 1", fifo_flush);
        end
        test_flush_len("late_flush");
        do_burst(24'hFFFF80, 8'd64, 0, 1'b0, "late_n0");
        do_burst(24'hFFFFC0, 8'd64, 0, 1'b0, "late_n1");
        do_burst(24'h000000, 8'd64, 0, 1'b0, "late_n2");
        do_burst(24'h000040, 8'd8,  0, 1'b0, "late_n3");
        finish_frame("late");
        checks++;
        if (late_frame !== 1'b1) begin
            errors++;
            $display("FAIL late_sticky: late_frame=%b expected 1", late_frame);
        end
    endtask

    task automatic test_underrun_reset();
        int n;
        data_req = 1'b1;
        fifo_empty = 1'b1;
        // Sampled in IDLE (counts), then 4 FLUSH cycles (do not count).
        pulse_frame_start();
        repeat (4) tick();
        checks++;
        if (underrun_cnt !== 16'd1) begin
            errors++;
            $display("FAIL urun_flush: underrun_cnt=%0d expected 1", underrun_cnt);
        end
        data_req = 1'b0;
        n = 0;
        while (!rd_req && n < 20) begin
            tick();
            n++;
        end
        data_req = 1'b1;
        repeat (65533) tick();
        checks++;
        if (underrun_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL urun_count: underrun_cnt=%h expected fffe", underrun_cnt);
        end
        repeat (3) tick();
        checks++;
        if (underrun_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL urun_sat: underrun_cnt=%h expected ffff", underrun_cnt);
        end
        checks++;
        if (rd_req !== 1'b1) begin
            errors++;
            $display("FAIL urun_req: rd_req=%b expected 1 (waiting for ack)", rd_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_req, rd_addr, rd_len, fifo_flush, frame_done, late_frame, underrun_cnt} !== 52'd0) begin
            errors++;
            $display("FAIL async_reset: req=%b addr=%h len=%0d flush=%b done=%b late=%b urun=%0d, expected all 0",
                     rd_req, rd_addr, rd_len, fifo_flush, frame_done, late_frame, underrun_cnt);
        end
        data_req = 1'b0;
        fifo_empty = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            tick();
            if (rd_req) n++;
        end
        checks++;
        if (n !== 0 || underrun_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset: req cycles=%0d urun=%0d, expected 0 0", n, underrun_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_hold();
        test_late_frame();
        test_underrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_rd_sched.md
LCD_RD_SCHED -- requirements
Module: lcd_rd_sched

Interface
REQ-001 Parameter H_DISP, default 800: active pixels per line.
REQ-002 Parameter V_DISP, default 480: active lines per frame.
REQ-003 Parameter BURST_LEN, default 64: maximum pixels per read request; range 1..255.
REQ-004 Parameter FIFO_DEPTH, default 512: pixel FIFO capacity in 16-bit words.
REQ-005 Parameter BASE_ADDR, default 24'h000000: word address of the first frame pixel.
REQ-006 Parameter FLUSH_CYC, default 4: number of cycles fifo_flush is held high.
REQ-007 lcd_pclk  input  1  pixel clock; all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 frame_start  input  1  single-cycle pulse at the start of LCD vertical sync.
REQ-010 fifo_wr_cnt  input  10  current FIFO fill level in words.
REQ-011 fifo_empty  input  1  FIFO empty flag.
REQ-012 data_req  input  1  LCD pixel request, one pixel popped per high cycle.
REQ-013 rd_req  output  1  memory read request.
REQ-014 rd_addr  output  24  word address of the request.
REQ-015 rd_len  output  8  pixels in the request.
REQ-016 rd_ack  input  1  memory has accepted the request.
REQ-017 rd_done  input  1  single-cycle pulse when the last word of the accepted request is written to the FIFO.
REQ-018 fifo_flush  output  1  clears the pixel FIFO.
REQ-019 frame_done  output  1  single-cycle pulse when all H_DISP*V_DISP pixels of a frame have been fetched.
REQ-020 late_frame  output  1  sticky flag: frame_start arrived before the frame was fully fetched.
REQ-021 underrun_cnt  output  16  saturating count of underrun cycles.

Function
REQ-022 The FSM SHALL have the states IDLE, FLUSH, CHECK, REQ, WAIT and DONE; exactly one state is active.
REQ-023 IDLE: on frame_start, go to FLUSH; set addr = BASE_ADDR and pix_left = H_DISP*V_DISP (19-bit counter).
REQ-024 FLUSH: fifo_flush = 1 for exactly FLUSH_CYC consecutive cycles, then go to CHECK.
REQ-025 CHECK, pix_left == 0: go to DONE.
REQ-026 CHECK, otherwise: len = min(BURST_LEN, pix_left); go to REQ only when (FIFO_DEPTH - fifo_wr_cnt) >= len; else stay in CHECK.
REQ-027 rd_req SHALL rise on the first REQ cycle.
REQ-028 rd_addr and rd_len SHALL be registered and stable from rd_req rise until rd_ack is sampled high.
REQ-029 rd_req SHALL drop on the cycle after rd_ack is sampled high, and the FSM goes to WAIT.
REQ-030 Only one request SHALL be outstanding at any time.
REQ-031 WAIT: on rd_done, addr += len (24-bit wrap allowed) and pix_left -= len; then go to CHECK.
REQ-032 rd_done outside WAIT SHALL be ignored.
REQ-033 DONE: frame_done = 1 for one cycle, then go to IDLE.
REQ-034 frame_start in FLUSH or CHECK SHALL restart the frame: reload addr and pix_left, go to FLUSH, set late_frame.
REQ-035 frame_start in REQ or WAIT SHALL set a pending flag and set late_frame.
REQ-036 The in-flight handshake SHALL complete normally.
REQ-037 On the WAIT exit triggered by rd_done with the pending flag set, the FSM goes to FLUSH with reloaded counters instead of CHECK, and the pending flag is cleared.
REQ-038 frame_start in DONE SHALL go to FLUSH, with frame_done still pulsing that cycle, and SHALL NOT set late_frame.
REQ-039 Underrun: every cycle with data_req && fifo_empty && state != FLUSH SHALL increment underrun_cnt, saturating at 16'hFFFF.
REQ-040 rd_len SHALL equal BURST_LEN except for the last burst of a frame, which is pix_left (default last burst = 384000 mod 64 = 0, so all bursts are 64).
REQ-041 Number of requests per frame SHALL equal ceil(H_DISP*V_DISP / BURST_LEN).

Reset
REQ-042 While rst_n = 0: state = IDLE, rd_req = 0, rd_addr = 0, rd_len = 0, fifo_flush = 0, frame_done = 0, late_frame = 0, underrun_cnt = 0, pending = 0.
REQ-043 Reset assertion SHALL take effect immediately, independent of the clock, including mid-handshake.
REQ-044 Release of reset SHALL be sampled on the next lcd_pclk edge.
REQ-045 After reset, no request SHALL be issued until frame_start.

Verification
REQ-046 Full frame: reset release, frame_start, fifo_wr_cnt = 0, rd_ack one cycle after rd_req, rd_done 8 cycles after ack -> fifo_flush high 4 cycles; 6000 requests with rd_len = 64 and rd_addr 0, 64, ... 383936; one frame_done pulse; late_frame = 0.
REQ-047 Backpressure: fifo_wr_cnt = 460 in CHECK -> no rd_req; drop fifo_wr_cnt to 448 -> rd_req on the next REQ cycle.
REQ-048 Short tail: H_DISP = 10, V_DISP = 10, BURST_LEN = 64 -> exactly two requests, rd_len 64 then 36, then frame_done.
REQ-049 Late frame: frame_start during WAIT of burst 3 -> request completes, then fifo_flush, then next rd_addr = BASE_ADDR; late_frame = 1 and held.
REQ-050 Handshake hold: rd_ack withheld 20 cycles -> rd_req, rd_addr and rd_len constant for all 20 cycles.
REQ-051 Underrun and reset: data_req = 1 with fifo_empty = 1 for 70000 cycles -> underrun_cnt = 16'hFFFF; then assert rst_n = 0 mid-REQ -> all outputs at reset values in the same cycle.
